// File: rtl/carry_chain_pkg.sv
// Shared types and elaboration helpers for the multi-cycle carry-chain adder.
//   state_t     : controller states (IDLE, RUN, DONE), 2-bit encoding
//   chunk_count : number of slice-wide chunks in a full-width operation
//   k_width     : width of the chunk index, ceil(log2(n)) with a minimum of 1
package carry_chain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned chunk_count(input int unsigned data_w,
                                                input int unsigned slice_w);
        return data_w / slice_w;
    endfunction

    function automatic int unsigned k_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/carry_chain_seq_slice.sv
// Combinational SLICE_W-bit carry chain in carry-mux form.
//   a, b      : slice operands
//   ci        : carry into bit 0
//   sum       : a + b + ci (modulo 2^SLICE_W)
//   co        : carry out of the top bit
//   c_msb_in  : carry into the top bit (used for signed overflow)
module carry_slice #(
    parameter int unsigned SLICE_W = 16
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] sum,
    output logic               co,
    output logic               c_msb_in
);

    always_comb begin
        logic c;
        logic p;
        sum      = '0;
        c_msb_in = 1'b0;
        c        = ci;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            p      = a[i] ^ b[i];
            sum[i] = p ^ c;
            if (i == SLICE_W - 1) begin
                c_msb_in = c;
            end
            // Propagate passes the incoming carry; otherwise a==b and a is the carry.
            c = p ? c : a[i];
        end
        co = c;
    end

endmodule

// File: rtl/carry_chain_seq.sv
// Multi-cycle wide adder/subtractor that time-shares one SLICE_W-bit carry
// chain across DATA_W/SLICE_W chunks, LSB chunk first.
//   CLK, RST_N           : clock, synchronous active-low reset
//   IN_VALID / IN_READY  : operation request handshake (ready only in IDLE)
//   A, B, SUB, CIN       : operands and mode, sampled on accept
//   OUT_VALID / OUT_READY: result handshake (valid only in DONE)
//   SUM, COUT, OVF       : registered result, carry-out (no-borrow for SUB),
//                          signed overflow
module carry_chain_seq
    import carry_chain_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned SLICE_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              SUB,
    input  logic              CIN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] SUM,
    output logic              COUT,
    output logic              OVF
);

    localparam int unsigned N  = chunk_count(DATA_W, SLICE_W);
    localparam int unsigned KW = k_width(N);

    generate
        if (SLICE_W < 1 || DATA_W < SLICE_W || (DATA_W % SLICE_W) != 0) begin : g_bad_params
            $error("carry_chain_seq: DATA_W must be a non-zero multiple of SLICE_W");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic [KW-1:0]     k;
    logic              carry;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              accept;
    logic              k_last;

    logic [SLICE_W-1:0] chunk_a;
    logic [SLICE_W-1:0] chunk_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_co;
    logic               slice_c_msb_in;

    assign k_last  = (k == KW'(N - 1));
    assign chunk_a = SLICE_W'(op_a >> (k * SLICE_W));
    assign chunk_b = SLICE_W'(op_b >> (k * SLICE_W));

    carry_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a        (chunk_a),
        .b        (chunk_b),
        .ci       (carry),
        .sum      (slice_sum),
        .co       (slice_co),
        .c_msb_in (slice_c_msb_in)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        IN_READY   = 1'b0;
        OUT_VALID  = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (k_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            k     <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            SUM   <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            op_a  <= A;
            op_b  <= SUB ? ~B : B;
            carry <= SUB ? 1'b1 : CIN;
            k     <= '0;
        end else if (state == RUN) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (k == KW'(i)) begin
                    SUM[i*SLICE_W +: SLICE_W] <= slice_sum;
                end
            end
            carry <= slice_co;
            if (k_last) begin
                COUT <= slice_co;
                OVF  <= slice_c_msb_in ^ slice_co;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_carry_chain_seq.sv
module tb_carry_chain_seq;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [63:0] A;
    logic [63:0] B;
    logic        SUB;
    logic        CIN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [63:0] SUM;
    logic        COUT;
    logic        OVF;

    int total = 0;
    int bad   = 0;

    carry_chain_seq #(
        .DATA_W  (64),
        .SLICE_W (16)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .SUB       (SUB),
        .CIN       (CIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .COUT      (COUT),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: plain 65-bit arithmetic and sign rules, no chunking.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input logic cin,
                                  output logic [63:0] s, output logic co,
                                  output logic ov);
        logic [64:0] wide;
        if (sub) begin
            wide = {1'b0, a} - {1'b0, b};
            s    = wide[63:0];
            co   = (a >= b);
            ov   = (a[63] != b[63]) && (s[63] != a[63]);
        end else begin
            wide = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            s    = wide[63:0];
            co   = wide[64];
            ov   = (a[63] == b[63]) && (s[63] != a[63]);
        end
    endfunction

    // Drives one operation from IDLE through result take-away; inputs are
    // scrambled right after accept so in-flight isolation is exercised too.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic cin,
                         output int lat, output logic [63:0] s,
                         output logic co, output logic ov, output logic tmo);
        A = a; B = b; SUB = sub; CIN = cin; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        A = rnd64(); B = rnd64(); SUB = 1'($urandom); CIN = 1'($urandom);
        lat = 0;
        while (!OUT_VALID && lat < 50) begin
            tick();
            lat++;
        end
        tmo = !OUT_VALID;
        s = SUM; co = COUT; ov = OVF;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
        total++; if (SUM !== 64'd0) begin bad++; $display("FAIL reset_sum got=%h exp=0", SUM); end
        total++; if ({COUT, OVF} !== 2'b00) begin bad++; $display("FAIL reset_cout_ovf got=%b exp=00", {COUT, OVF}); end
    endtask

    task automatic test_directed();
        logic [63:0] va [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h7FFF_FFFF_FFFF_FFFF,
                                64'h8000_0000_0000_0000, 64'h0000_0000_0000_FFFF};
        logic [63:0] vb [5] = '{64'd1, 64'd7, 64'd1, 64'd1, 64'd0};
        logic        vs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] es [5] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000,
                                64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0001_0000};
        logic        ec [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        logic [63:0] s;
        logic co, ov, tmo;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vs[i], vc[i], lat, s, co, ov, tmo);
            total++; if (tmo !== 1'b0 || lat != 4) begin bad++; $display("FAIL directed%0d_latency got=%0d exp=4 timeout=%b", i, lat, tmo); end
            total++; if (s !== es[i]) begin bad++; $display("FAIL directed%0d_sum got=%h exp=%h", i, s, es[i]); end
            total++; if (co !== ec[i]) begin bad++; $display("FAIL directed%0d_cout got=%b exp=%b", i, co, ec[i]); end
            total++; if (ov !== eo[i]) begin bad++; $display("FAIL directed%0d_ovf got=%b exp=%b", i, ov, eo[i]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] edges [6] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                   64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'h0000_FFFF_0000_FFFF};
        int lat;
        logic [63:0] a, b, s, es;
        logic sub, cin, co, ov, ec, eo, tmo;
        for (int i = 0; i < 40; i++) begin
            a   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : rnd64();
            b   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : rnd64();
            sub = 1'($urandom);
            cin = 1'($urandom);
            model(a, b, sub, cin, es, ec, eo);
            do_op(a, b, sub, cin, lat, s, co, ov, tmo);
            total++;
            if (tmo !== 1'b0 || lat != 4 || s !== es || co !== ec || ov !== eo) begin
                bad++;
                $display("FAIL random%0d a=%h b=%h sub=%b cin=%b got sum=%h c=%b v=%b lat=%0d exp sum=%h c=%b v=%b lat=4",
                         i, a, b, sub, cin, s, co, ov, lat, es, ec, eo);
            end
        end
    endtask

    task automatic test_hold();
        logic [63:0] es, es2;
        logic ec, eo, ec2, eo2;
        logic [63:0] na, nb;
        int lat;
        model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, es, ec, eo);
        A = 64'h1234_5678_9ABC_DEF0; B = 64'hFEDC_BA98_7654_3210; SUB = 1'b0; CIN = 1'b1;
        IN_VALID = 1'b1;
        tick();
        na = rnd64(); nb = rnd64();
        A = na; B = nb; SUB = 1'b1; CIN = 1'b0;
        model(na, nb, 1'b1, 1'b0, es2, ec2, eo2);
        lat = 0;
        while (!OUT_VALID && lat < 50) begin tick(); lat++; end
        total++; if (lat != 4) begin bad++; $display("FAIL hold_latency got=%0d exp=4", lat); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || SUM !== es || COUT !== ec || OVF !== eo) begin
                bad++;
                $display("FAIL hold_cycle%0d got v=%b r=%b sum=%h c=%b o=%b exp v=1 r=0 sum=%h c=%b o=%b",
                         i, OUT_VALID, IN_READY, SUM, COUT, OVF, es, ec, eo);
            end
            tick();
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        total++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin bad++; $display("FAIL hold_release got r=%b v=%b exp r=1 v=0", IN_READY, OUT_VALID); end
        tick();
        IN_VALID = 1'b0;
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL hold_next_accept got r=%b exp 0", IN_READY); end
        lat = 0;
        while (!OUT_VALID && lat < 50) begin tick(); lat++; end
        total++;
        if (lat != 4 || SUM !== es2 || COUT !== ec2 || OVF !== eo2) begin
            bad++;
            $display("FAIL hold_second_op got sum=%h c=%b o=%b lat=%0d exp sum=%h c=%b o=%b lat=4",
                     SUM, COUT, OVF, lat, es2, ec2, eo2);
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [63:0] s;
        logic co, ov, tmo, seen;
        A = rnd64(); B = rnd64(); SUB = 1'b0; CIN = 1'b1; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        total++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin bad++; $display("FAIL midrst_handshake got r=%b v=%b exp r=1 v=0", IN_READY, OUT_VALID); end
        total++; if (SUM !== 64'd0) begin bad++; $display("FAIL midrst_sum got=%h exp=0", SUM); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (OUT_VALID !== 1'b0) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_valid got pulse=%b exp 0", seen); end
        do_op(64'd3, 64'd4, 1'b0, 1'b0, lat, s, co, ov, tmo);
        total++; if (tmo !== 1'b0 || lat != 4 || s !== 64'd7 || co !== 1'b0 || ov !== 1'b0) begin
            bad++; $display("FAIL midrst_followup got sum=%h c=%b o=%b lat=%0d exp sum=7 c=0 o=0 lat=4", s, co, ov, lat);
        end
    endtask

    initial begin
        RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        A = '0; B = '0; SUB = 1'b0; CIN = 1'b0;
        #2;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
